// File: rtl/riscv_core.sv
// Single-cycle RV32I core with its own instruction memory, register file and data memory.
// Fetch, decode, execute, load/store and writeback all happen between two rising edges.

module riscv_imem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0] i_addr,
   output logic [31:0]   o_rdata
);
   logic [31:0] mem [0:DEPTH-1];

   assign o_rdata = mem[i_addr];
endmodule

module riscv_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_we,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   output logic [31:0] o_rs1_data,
   output logic [31:0] o_rs2_data
);
   logic [31:0] regfile [0:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regfile[i] <= '0;
      end else if (i_we && i_rd != 5'd0) begin
         regfile[i_rd] <= i_wdata;
      end
   end

   assign o_rs1_data = (i_rs1 == 5'd0) ? '0 : regfile[i_rs1];
   assign o_rs2_data = (i_rs2 == 5'd0) ? '0 : regfile[i_rs2];
endmodule

module riscv_dmem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] i_addr,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);
   logic [31:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++)
            if (i_be[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
   end

   assign o_rdata = mem[i_addr];
endmodule

module riscv_core #(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256
) (
   input logic clk,
   input logic rst_n
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   logic [31:0] r_pc;
   logic [31:0] w_instr, w_rs1_val, w_rs2_val, w_dmem_rdata;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [31:0] w_alu_b, w_alu_res, w_ld_val, w_st_data, w_rd_val, w_next_pc, w_addr;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
   logic [3:0]  w_st_be;
   logic        w_rd_we, w_st_we, w_taken;

   riscv_imem #(.DEPTH(IMEM_DEPTH)) Instr_Mem (
      .i_addr  (IAW'(r_pc >> 2)),
      .o_rdata (w_instr)
   );

   assign w_opcode = w_instr[6:0];
   assign w_rd     = w_instr[11:7];
   assign w_funct3 = w_instr[14:12];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];

   assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
   assign w_imm_u = {w_instr[31:12], 12'h000};
   assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

   riscv_regfile Reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (w_rd_we),
      .i_rd       (w_rd),
      .i_wdata    (w_rd_val),
      .i_rs1      (w_rs1),
      .i_rs2      (w_rs2),
      .o_rs1_data (w_rs1_val),
      .o_rs2_data (w_rs2_val)
   );

   // instr[30] only selects SUB for register ops; for ADDI it is an immediate bit
   assign w_alu_b = (w_opcode == OP_REG) ? w_rs2_val : w_imm_i;
   assign w_shamt = w_alu_b[4:0];

   always_comb begin
      w_alu_res = '0;
      case (w_funct3)
         3'd0: w_alu_res = (w_opcode == OP_REG && w_instr[30]) ? w_rs1_val - w_alu_b
                                                                : w_rs1_val + w_alu_b;
         3'd1: w_alu_res = w_rs1_val << w_shamt;
         3'd2: w_alu_res = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
         3'd3: w_alu_res = {31'd0, w_rs1_val < w_alu_b};
         3'd4: w_alu_res = w_rs1_val ^ w_alu_b;
         3'd5: w_alu_res = w_instr[30] ? 32'($signed(w_rs1_val) >>> w_shamt)
                                       : w_rs1_val >> w_shamt;
         3'd6: w_alu_res = w_rs1_val | w_alu_b;
         default: w_alu_res = w_rs1_val & w_alu_b;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (w_funct3)
         3'd0: w_taken = (w_rs1_val == w_rs2_val);
         3'd1: w_taken = (w_rs1_val != w_rs2_val);
         3'd4: w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
         3'd5: w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
         3'd6: w_taken = (w_rs1_val <  w_rs2_val);
         3'd7: w_taken = (w_rs1_val >= w_rs2_val);
         default: w_taken = 1'b0;
      endcase
   end

   riscv_dmem #(.DEPTH(DMEM_DEPTH)) Data_Mem (
      .clk     (clk),
      .i_addr  (DAW'(w_addr >> 2)),
      .i_we    (w_st_we & rst_n),
      .i_be    (w_st_be),
      .i_wdata (w_st_data),
      .o_rdata (w_dmem_rdata)
   );

   assign w_ld_byte = 8'(w_dmem_rdata >> {w_addr[1:0], 3'b000});
   assign w_ld_half = 16'(w_dmem_rdata >> {w_addr[1], 4'b0000});

   always_comb begin
      w_ld_val = '0;
      case (w_funct3)
         3'd0: w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'd1: w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
         3'd2: w_ld_val = w_dmem_rdata;
         3'd4: w_ld_val = {24'd0, w_ld_byte};
         3'd5: w_ld_val = {16'd0, w_ld_half};
         default: w_ld_val = '0;
      endcase
   end

   // Store data is replicated across lanes; the byte enables pick the live ones
   always_comb begin
      w_st_be   = 4'b0000;
      w_st_data = w_rs2_val;
      case (w_funct3)
         3'd0: begin
            w_st_be   = 4'b0001 << w_addr[1:0];
            w_st_data = {4{w_rs2_val[7:0]}};
         end
         3'd1: begin
            w_st_be   = w_addr[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{w_rs2_val[15:0]}};
         end
         3'd2: w_st_be = 4'b1111;
         default: w_st_be = 4'b0000;
      endcase
   end

   always_comb begin
      w_next_pc = r_pc + 32'd4;
      w_rd_we   = 1'b0;
      w_rd_val  = w_alu_res;
      w_st_we   = 1'b0;
      w_addr    = w_rs1_val + w_imm_i;
      case (w_opcode)
         OP_LUI: begin
            w_rd_we  = 1'b1;
            w_rd_val = w_imm_u;
         end
         OP_AUIPC: begin
            w_rd_we  = 1'b1;
            w_rd_val = r_pc + w_imm_u;
         end
         OP_JAL: begin
            w_rd_we   = 1'b1;
            w_rd_val  = r_pc + 32'd4;
            w_next_pc = r_pc + w_imm_j;
         end
         OP_JALR: begin
            if (w_funct3 == 3'd0) begin
               w_rd_we   = 1'b1;
               w_rd_val  = r_pc + 32'd4;
               w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
            end
         end
         OP_BRANCH: if (w_taken) w_next_pc = r_pc + w_imm_b;
         OP_LOAD: begin
            w_rd_we  = (w_funct3 != 3'd3) && (w_funct3 < 3'd6);
            w_rd_val = w_ld_val;
         end
         OP_STORE: begin
            w_addr  = w_rs1_val + w_imm_s;
            w_st_we = (w_funct3 < 3'd3);
         end
         OP_IMM, OP_REG: w_rd_we = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pc <= '0;
      else        r_pc <= w_next_pc;
   end
endmodule

// File: tb/tb_riscv_core.sv
// Bench for riscv_core: directed programs plus random programs, each cycle scored
// against an instruction-level interpreter of RV32I running alongside the DUT.

module tb_riscv_core;
   localparam int IMEM_DEPTH = 256;
   localparam int DMEM_DEPTH = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   riscv_core #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] val;
      logic        st;
      int          idx;
      logic [31:0] word;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] prog[$];

   logic [31:0] m_imem [IMEM_DEPTH];
   logic [31:0] m_dmem [DMEM_DEPTH];
   logic [31:0] m_reg  [32];
   logic [31:0] m_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, want);
      end
   endtask

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      logic [11:0] im;
      im = 12'(imm);
      return {im, 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      logic [11:0] im;
      im = 12'(imm);
      return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      logic [12:0] im;
      im = 13'(imm);
      return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
      return {20'(imm), 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_j(int imm, int rd);
      logic [20:0] im;
      im = 21'(imm);
      return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
   endfunction

   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   // ---------------- reference interpreter ----------------
   task automatic model_reset();
      m_pc = '0;
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
   endtask

   task automatic model_step();
      exp_t        e;
      logic [31:0] ins, a, b, y, ii, is, ib, iu, ij, addr, w, nxt, res;
      logic [7:0]  bv;
      logic [15:0] hv;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        wr, tk;
      int          sh, idx;
      ins = m_imem[(m_pc >> 2) % IMEM_DEPTH];
      rd  = ins[11:7];
      f3  = ins[14:12];
      a   = m_reg[ins[19:15]];
      b   = m_reg[ins[24:20]];
      ii  = 32'($signed(ins[31:20]));
      is  = 32'($signed({ins[31:25], ins[11:7]}));
      ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      iu  = {ins[31:12], 12'h000};
      ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      nxt = m_pc + 4;
      wr  = 1'b0;
      res = '0;
      e.st = 1'b0; e.idx = 0; e.word = '0;
      case (ins[6:0])
         7'h37: begin wr = 1'b1; res = iu; end
         7'h17: begin wr = 1'b1; res = m_pc + iu; end
         7'h6F: begin wr = 1'b1; res = m_pc + 4; nxt = m_pc + ij; end
         7'h67: if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 4; nxt = (a + ii) & ~32'd1; end
         7'h63: begin
            case (f3)
               3'd0: tk = (a == b);
               3'd1: tk = (a != b);
               3'd4: tk = (int'(a) <  int'(b));
               3'd5: tk = (int'(a) >= int'(b));
               3'd6: tk = (a <  b);
               3'd7: tk = (a >= b);
               default: tk = 1'b0;
            endcase
            if (tk) nxt = m_pc + ib;
         end
         7'h03: begin
            addr = a + ii;
            w  = m_dmem[(addr >> 2) % DMEM_DEPTH];
            bv = 8'(w >> (8 * addr[1:0]));
            hv = 16'(w >> (16 * addr[1]));
            wr = 1'b1;
            case (f3)
               3'd0: res = 32'($signed(bv));
               3'd1: res = 32'($signed(hv));
               3'd2: res = w;
               3'd4: res = {24'd0, bv};
               3'd5: res = {16'd0, hv};
               default: wr = 1'b0;
            endcase
         end
         7'h23: begin
            addr = a + is;
            idx  = int'((addr >> 2) % DMEM_DEPTH);
            w    = m_dmem[idx];
            case (f3)
               3'd0: w[8 * addr[1:0] +: 8] = b[7:0];
               3'd1: w[16 * addr[1] +: 16] = b[15:0];
               3'd2: w = b;
               default: ;
            endcase
            if (f3 < 3'd3) begin
               m_dmem[idx] = w;
               e.st = 1'b1; e.idx = idx; e.word = w;
            end
         end
         7'h13, 7'h33: begin
            wr = 1'b1;
            y  = (ins[6:0] == 7'h33) ? b : ii;
            sh = int'(y[4:0]);
            case (f3)
               3'd0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - y : a + y;
               3'd1: res = a << sh;
               3'd2: res = (int'(a) < int'(y)) ? 32'd1 : 32'd0;
               3'd3: res = (a < y) ? 32'd1 : 32'd0;
               3'd4: res = a ^ y;
               3'd5: res = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
               3'd6: res = a | y;
               default: res = a & y;
            endcase
         end
         default: ;
      endcase
      if (wr && rd != 5'd0) m_reg[rd] = res;
      m_pc  = nxt;
      e.pc  = nxt;
      e.wr  = wr;
      e.rd  = rd;
      e.val = res;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pc", dut.r_pc, e.pc);
         if (e.wr)
            check($sformatf("wb x%0d", e.rd), dut.Reg.regfile[e.rd], (e.rd == 5'd0) ? 32'd0 : e.val);
         if (e.st)
            check($sformatf("st dmem[%0d]", e.idx), dut.Data_Mem.mem[e.idx], e.word);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load_prog();
      for (int i = 0; i < IMEM_DEPTH; i++) begin
         m_imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
         dut.Instr_Mem.mem[i] = m_imem[i];
      end
   endtask

   task automatic init_dmem(input bit rnd);
      for (int i = 0; i < DMEM_DEPTH; i++) begin
         m_dmem[i] = rnd ? $urandom : 32'd0;
         dut.Data_Mem.mem[i] = m_dmem[i];
      end
   endtask

   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      exp_q.delete();
      #(hold);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         model_step();
         @(posedge clk);
         @(negedge clk);
      end
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      int k, rd, rs1, rs2, f3, imm;
      logic [31:0] r;
      k   = int'($urandom_range(0, 13));
      rd  = int'($urandom_range(0, 7));
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      r   = $urandom;
      case (k)
         0, 13: return enc_u(int'(r), rd, 7'h37);
         1:  return enc_u(int'(r), rd, 7'h17);
         2:  return enc_j((int'($urandom_range(0, 64)) - 32) * 4, rd);
         3:  return enc_i(int'($urandom_range(0, 4095)) - 2048, rs1, 0, rd, 7'h67);
         4: begin
            case ($urandom_range(0, 5))
               0: f3 = 0; 1: f3 = 1; 2: f3 = 4; 3: f3 = 5; 4: f3 = 6; default: f3 = 7;
            endcase
            return enc_b((int'($urandom_range(0, 32)) - 16) * 4, rs2, rs1, f3);
         end
         5: begin
            case ($urandom_range(0, 4))
               0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 4; default: f3 = 5;
            endcase
            return enc_i(int'($urandom_range(0, 4095)), rs1, f3, rd, 7'h03);
         end
         6:  return enc_s(int'($urandom_range(0, 4095)), rs2, rs1, int'($urandom_range(0, 2)));
         7, 8: begin
            f3  = int'($urandom_range(0, 7));
            imm = int'($urandom_range(0, 4095));
            if (f3 == 1) imm = imm & 31;
            if (f3 == 5) imm = (imm & 31) | (int'($urandom_range(0, 1)) << 10);
            return enc_i(imm, rs1, f3, rd, 7'h13);
         end
         9, 10: begin
            f3 = int'($urandom_range(0, 7));
            return enc_r((f3 == 0 || f3 == 5) ? int'($urandom_range(0, 1)) * 32 : 0, rs2, rs1, f3, rd);
         end
         11: begin
            case ($urandom_range(0, 3))
               0: return {r[31:7], 7'h0F};
               1: return {r[31:7], 7'h73};
               2: return {r[31:7], 7'h00};
               default: return {r[31:7], 7'h7F};
            endcase
         end
         default: return enc_i(int'($urandom_range(0, 4095)) - 2048, 0, 0, rd, 7'h13);
      endcase
   endfunction

   initial begin
      // ---- immediate arithmetic ----
      prog.delete();
      prog.push_back(enc_i(5, 0, 0, 1, 7'h13));
      prog.push_back(enc_i(-3, 0, 0, 2, 7'h13));
      prog.push_back(enc_r(0, 2, 1, 0, 3));
      prog.push_back(enc_r(32, 2, 1, 0, 4));
      load_prog();
      init_dmem(1'b0);
      #1;
      check("reset pc", dut.r_pc, 32'd0);
      check("reset x1", dut.Reg.regfile[1], 32'd0);
      do_reset(20);
      run(20);
      for (int i = 0; i < 32; i++) begin
         logic [31:0] want;
         case (i)
            1: want = 32'd5;
            2: want = 32'hFFFF_FFFD;
            3: want = 32'd2;
            4: want = 32'd8;
            default: want = 32'd0;
         endcase
         check($sformatf("arith x%0d", i), dut.Reg.regfile[i], want);
      end

      // ---- x0 and logic ops ----
      prog.delete();
      prog.push_back(enc_i(-3, 0, 0, 2, 7'h13));
      prog.push_back(enc_i(7, 0, 0, 0, 7'h13));
      prog.push_back(enc_i(32'hF0, 0, 6, 5, 7'h13));
      prog.push_back(enc_i(32'h30, 5, 7, 6, 7'h13));
      prog.push_back(enc_i(4, 5, 1, 7, 7'h13));
      prog.push_back(enc_i(32'h401, 2, 5, 8, 7'h13));
      load_prog();
      do_reset(12);
      run(10);
      check("logic x0", dut.Reg.regfile[0], 32'd0);
      check("logic x5", dut.Reg.regfile[5], 32'h0000_00F0);
      check("logic x6", dut.Reg.regfile[6], 32'h0000_0030);
      check("logic x7", dut.Reg.regfile[7], 32'h0000_0F00);
      check("logic x8", dut.Reg.regfile[8], 32'hFFFF_FFFE);

      // ---- memory lanes ----
      prog.delete();
      prog.push_back(enc_u(32'h80000, 1, 7'h37));
      prog.push_back(enc_i(1, 1, 0, 1, 7'h13));
      prog.push_back(enc_s(8, 1, 0, 2));
      prog.push_back(enc_i(8, 0, 0, 2, 7'h03));
      prog.push_back(enc_i(11, 0, 4, 3, 7'h03));
      prog.push_back(enc_i(10, 0, 1, 4, 7'h03));
      prog.push_back(enc_s(13, 1, 0, 0));
      prog.push_back(enc_i(12, 0, 2, 5, 7'h03));
      load_prog();
      init_dmem(1'b0);
      do_reset(12);
      run(10);
      check("mem x1", dut.Reg.regfile[1], 32'h8000_0001);
      check("mem x2", dut.Reg.regfile[2], 32'h0000_0001);
      check("mem x3", dut.Reg.regfile[3], 32'h0000_0080);
      check("mem x4", dut.Reg.regfile[4], 32'hFFFF_8000);
      check("mem x5", dut.Reg.regfile[5], 32'h0000_0100);
      check("mem word2", dut.Data_Mem.mem[2], 32'h8000_0001);

      // ---- branch loop and not-taken blt ----
      prog.delete();
      prog.push_back(enc_i(4, 0, 0, 10, 7'h13));
      prog.push_back(enc_i(1, 1, 0, 1, 7'h13));
      prog.push_back(enc_b(-4, 10, 1, 1));
      prog.push_back(enc_b(8, 1, 10, 4));
      prog.push_back(enc_i(1, 0, 0, 11, 7'h13));
      prog.push_back(enc_i(2, 0, 0, 12, 7'h13));
      load_prog();
      do_reset(12);
      run(16);
      check("br x1", dut.Reg.regfile[1], 32'd4);
      check("br fallthru x11", dut.Reg.regfile[11], 32'd1);
      check("br x12", dut.Reg.regfile[12], 32'd2);

      // ---- jal / jalr ----
      prog.delete();
      prog.push_back(enc_j(8, 1));
      prog.push_back(enc_i(1, 0, 0, 5, 7'h13));
      prog.push_back(enc_i(0, 1, 0, 2, 7'h67));
      load_prog();
      do_reset(12);
      run(1);
      check("jal pc", dut.r_pc, 32'd8);
      check("jal x1", dut.Reg.regfile[1], 32'd4);
      run(1);
      check("jalr pc", dut.r_pc, 32'd4);
      check("jalr x2", dut.Reg.regfile[2], 32'd12);
      check("jal skipped x5", dut.Reg.regfile[5], 32'd0);
      run(1);
      check("jalr resume x5", dut.Reg.regfile[5], 32'd1);

      // ---- asynchronous reset mid-run ----
      prog.delete();
      prog.push_back(enc_i(1, 1, 0, 1, 7'h13));
      prog.push_back(enc_j(-4, 0));
      load_prog();
      do_reset(12);
      run(5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async rst pc", dut.r_pc, 32'd0);
      for (int i = 0; i < 32; i++)
         check($sformatf("async rst x%0d", i), dut.Reg.regfile[i], 32'd0);
      @(posedge clk);
      #1;
      check("rst held pc", dut.r_pc, 32'd0);
      do_reset(4);
      run(10);
      check("restart x1", dut.Reg.regfile[1], 32'd5);
      check("restart pc", dut.r_pc, 32'd0);

      // ---- random programs ----
      for (int t = 0; t < 4; t++) begin
         prog.delete();
         for (int i = 0; i < IMEM_DEPTH; i++) prog.push_back(rand_instr());
         load_prog();
         init_dmem(1'b1);
         do_reset(12);
         run(400);
         check($sformatf("rnd%0d pc", t), dut.r_pc, m_pc);
         for (int i = 0; i < 32; i++)
            check($sformatf("rnd%0d x%0d", t, i), dut.Reg.regfile[i], m_reg[i]);
         for (int i = 0; i < DMEM_DEPTH; i++)
            check($sformatf("rnd%0d dmem[%0d]", t, i), dut.Data_Mem.mem[i], m_dmem[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
